// File: rtl/pep_ks_mod_switch_serializer.sv
// pep_ks_mod_switch_serializer
// Takes one key-switch result word per KS column. A word holds BATCH_PBS_NB LWE coefs,
// each with a small signed correction. The block serializes the valid PBS slots, from rp
// up to wp, at one coef per cycle. It adds the correction to each coef and mod-switches
// the sum down to MS_W bits with round-half-up.
//
// Ports
//   clk, s_rst_n          clock, synchronous active-low reset
//   in_flush              1-cycle pulse: drop the held word and everything in flight
//   in_ks_loop            coef index carried by the word
//   in_wp / in_rp         slot write/read pointers, MSB is the wrap bit
//   in_lwe_a / in_corr_a  packed coefs and signed corrections, slot i at [i*W +: W]
//   in_vld / in_rdy       input word handshake
//   out_pid/out_idx/out_coef/out_last  serialized coef for the per-PBS LWE buffer writer
//   out_vld / out_rdy     output coef handshake
//   dbg_state             current FSM state (0 = IDLE, 1 = SERIAL)
//
// Handshake rule, both sides: a transfer happens on a rising edge where vld & rdy are
// both high. The producer holds vld and its data stable until that transfer happens, and
// vld does not depend on rdy.
module pep_ks_mod_switch_serializer #(
    parameter int BATCH_PBS_NB   = 16,
    parameter int PID_W          = 4,
    parameter int LWE_COEF_W     = 21,
    parameter int KS_MAX_ERROR_W = 4,
    parameter int MS_W           = 12,
    parameter int KS_LOOP_W      = 10,
    parameter int LWE_K          = 630
) (
    input  logic                                   clk,
    input  logic                                   s_rst_n,
    input  logic                                   in_flush,
    input  logic [KS_LOOP_W-1:0]                   in_ks_loop,
    input  logic [PID_W:0]                         in_wp,
    input  logic [PID_W:0]                         in_rp,
    input  logic [BATCH_PBS_NB*LWE_COEF_W-1:0]     in_lwe_a,
    input  logic [BATCH_PBS_NB*KS_MAX_ERROR_W-1:0] in_corr_a,
    input  logic                                   in_vld,
    output logic                                   in_rdy,
    output logic [PID_W-1:0]                       out_pid,
    output logic [KS_LOOP_W-1:0]                   out_idx,
    output logic [MS_W-1:0]                        out_coef,
    output logic                                   out_last,
    output logic                                   out_vld,
    input  logic                                   out_rdy,
    output logic [0:0]                             dbg_state
);

    localparam int D = LWE_COEF_W - MS_W;
    localparam logic [KS_LOOP_W-1:0] LAST_IDX = KS_LOOP_W'(LWE_K);

    typedef enum logic [0:0] {IDLE = 1'b0, SERIAL = 1'b1} state_e;

    state_e state_q, state_d;
    logic [PID_W:0]   cnt_q, cnt_d;
    logic [PID_W:0]   elt_nb_q;
    logic [PID_W:0]   last_cnt;
    logic [PID_W:0]   in_elt_nb;
    logic [PID_W-1:0] rp_q;
    logic [KS_LOOP_W-1:0] idx_q;
    logic [BATCH_PBS_NB*LWE_COEF_W-1:0]     lwe_q;
    logic [BATCH_PBS_NB*KS_MAX_ERROR_W-1:0] corr_q;

    logic adv, accept, load, issue, last_issue;

    // Slot selection and correction add for the coef being issued.
    logic [PID_W-1:0]          slot;
    logic [LWE_COEF_W-1:0]     sel_lwe;
    logic [KS_MAX_ERROR_W-1:0] sel_corr;
    logic [LWE_COEF_W-1:0]     sum;

    // Stage 1 registers
    logic                  s1_vld;
    logic [PID_W-1:0]      s1_pid;
    logic [KS_LOOP_W-1:0]  s1_idx;
    logic [LWE_COEF_W-1:0] s1_v;
    logic [MS_W-1:0]       rounded;

    // Pointer difference wraps modulo 2^(PID_W+1), which gives 0..BATCH_PBS_NB.
    assign in_elt_nb  = in_wp - in_rp;
    assign last_cnt   = elt_nb_q - 1'b1;
    assign last_issue = (cnt_q == last_cnt);
    assign adv        = ~out_vld | out_rdy;
    assign accept     = in_vld & in_rdy;
    assign dbg_state  = state_q;

    assign slot     = rp_q + cnt_q[PID_W-1:0];
    assign sel_lwe  = lwe_q[slot*LWE_COEF_W +: LWE_COEF_W];
    assign sel_corr = corr_q[slot*KS_MAX_ERROR_W +: KS_MAX_ERROR_W];
    assign sum      = sel_lwe + {{(LWE_COEF_W-KS_MAX_ERROR_W){sel_corr[KS_MAX_ERROR_W-1]}}, sel_corr};
    // Round half up on the dropped bits. The carry out of the top bit wraps at 2N.
    assign rounded  = s1_v[LWE_COEF_W-1:D] + {{(MS_W-1){1'b0}}, s1_v[D-1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        issue   = 1'b0;
        // A new word is taken while idle, or in the same cycle the last slot of the
        // current word leaves, so consecutive words stream without a bubble.
        in_rdy  = ~in_flush & ((state_q == IDLE) | ((state_q == SERIAL) & last_issue & adv));
        if (in_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Words with no valid slot are consumed and dropped.
                    if (accept && in_elt_nb != '0) begin
                        load    = 1'b1;
                        state_d = SERIAL;
                        cnt_d   = '0;
                    end
                end
                SERIAL: begin
                    if (adv) begin
                        issue = 1'b1;
                        if (last_issue) begin
                            cnt_d = '0;
                            if (accept && in_elt_nb != '0) begin
                                load = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            elt_nb_q <= '0;
            rp_q     <= '0;
            idx_q    <= '0;
            lwe_q    <= '0;
            corr_q   <= '0;
            s1_vld   <= 1'b0;
            s1_pid   <= '0;
            s1_idx   <= '0;
            s1_v     <= '0;
            out_vld  <= 1'b0;
            out_pid  <= '0;
            out_idx  <= '0;
            out_coef <= '0;
            out_last <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                elt_nb_q <= in_elt_nb;
                rp_q     <= in_rp[PID_W-1:0];
                idx_q    <= in_ks_loop;
                lwe_q    <= in_lwe_a;
                corr_q   <= in_corr_a;
            end
            if (in_flush) begin
                s1_vld  <= 1'b0;
                out_vld <= 1'b0;
            end else if (adv) begin
                s1_vld <= issue;
                if (issue) begin
                    s1_pid <= slot;
                    s1_idx <= idx_q;
                    s1_v   <= sum;
                end
                out_vld <= s1_vld;
                if (s1_vld) begin
                    out_pid  <= s1_pid;
                    out_idx  <= s1_idx;
                    out_coef <= rounded;
                    out_last <= (s1_idx == LAST_IDX);
                end
            end
        end
    end

    // The pointers must never describe more slots than a word holds.
    assert property (@(posedge clk) disable iff (!s_rst_n)
        (in_vld && in_rdy) |-> (in_elt_nb <= (PID_W+1)'(BATCH_PBS_NB)));

endmodule

// File: tb/tb_pep_ks_mod_switch_serializer.sv
module tb_pep_ks_mod_switch_serializer;

  localparam int NB    = 16;
  localparam int PW    = 4;
  localparam int CW    = 21;
  localparam int EW    = 4;
  localparam int MW    = 12;
  localparam int KW    = 10;
  localparam int LWE_K = 630;
  localparam int OW    = PW + KW + MW + 1;

  logic          clk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic          in_flush = 1'b0;
  logic [KW-1:0] in_ks_loop = '0;
  logic [PW:0]   in_wp = '0;
  logic [PW:0]   in_rp = '0;
  logic [NB*CW-1:0] in_lwe_a = '0;
  logic [NB*EW-1:0] in_corr_a = '0;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [PW-1:0] out_pid;
  logic [KW-1:0] out_idx;
  logic [MW-1:0] out_coef;
  logic          out_last;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [0:0]    dbg_state;

  pep_ks_mod_switch_serializer dut (
    .clk        (clk),
    .s_rst_n    (s_rst_n),
    .in_flush   (in_flush),
    .in_ks_loop (in_ks_loop),
    .in_wp      (in_wp),
    .in_rp      (in_rp),
    .in_lwe_a   (in_lwe_a),
    .in_corr_a  (in_corr_a),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .out_pid    (out_pid),
    .out_idx    (out_idx),
    .out_coef   (out_coef),
    .out_last   (out_last),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];
  logic [CW-1:0] w_lwe[NB];
  logic [EW-1:0] w_corr[NB];
  logic rnd_bp = 1'b0;
  int pops = 0;
  int streak = 0;
  int max_streak = 0;
  logic prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: correction add modulo 2^21, then round-half-up to 12 bits with wrap.
  function automatic logic [OW-1:0] exp_word(input int slot, input logic [KW-1:0] idx);
    logic [CW-1:0] v;
    logic [MW-1:0] c;
    v = w_lwe[slot] + {{(CW-EW){w_corr[slot][EW-1]}}, w_corr[slot]};
    c = MW'((v >> (CW-MW)) + ((v >> (CW-MW-1)) & 1));
    return {PW'(slot), idx, c, (idx == KW'(LWE_K))};
  endfunction

  // Backpressure source, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_rdy = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [OW-1:0] obs;
    if (s_rst_n) begin
      obs = {out_pid, out_idx, out_coef, out_last};
      if (prev_stall) begin
        check("hold_vld", 32'(out_vld), 32'd1);
        check("hold_data", 32'(obs), 32'(prev_data));
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(obs), 32'hFFFF_FFFF);
        end else begin
          check("out_data", 32'(obs), 32'(exp_q.pop_front()));
          pops++;
        end
      end
      prev_stall = out_vld && !out_rdy;
      prev_data  = obs;
      streak = out_vld ? streak + 1 : 0;
      if (streak > max_streak) max_streak = streak;
    end
  end

  // ---------------- driver tasks (entered and left just after a rising edge) ----------------
  task automatic send_word(input logic [KW-1:0] ks, input logic [PW:0] wp, input logic [PW:0] rp);
    int n;
    logic [PW:0] elt;
    for (int i = 0; i < NB; i++) begin
      in_lwe_a[i*CW +: CW]  = w_lwe[i];
      in_corr_a[i*EW +: EW] = w_corr[i];
    end
    in_ks_loop = ks;
    in_wp = wp;
    in_rp = rp;
    in_vld = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) check("send_timeout", 32'd0, 32'd1);
    elt = wp - rp;
    for (int k = 0; k < int'(elt); k++) exp_q.push_back(exp_word((int'(rp) + k) % NB, ks));
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NB; i++) begin
      w_lwe[i]  = CW'($urandom);
      w_corr[i] = EW'($urandom_range(0, 15));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int base;
    logic [PW:0] rp;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", 32'({out_pid, out_idx, out_coef, out_last}), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;

    // Full word, coef i in slot i, with latency check
    for (int i = 0; i < NB; i++) begin
      w_lwe[i]  = CW'(i << 9);
      w_corr[i] = '0;
    end
    send_word(10'd5, 5'd16, 5'd0);
    @(negedge clk);
    @(negedge clk);
    check("lat_early", 32'(out_vld), 32'd0);
    @(negedge clk);
    check("lat_first", 32'(out_vld), 32'd1);
    wait_drain();

    // Rounding and wrap corners
    for (int i = 0; i < NB; i++) begin
      w_lwe[i]  = '0;
      w_corr[i] = '0;
    end
    w_lwe[0]  = 21'h1FFFFF;
    w_lwe[1]  = 21'h000100;
    w_corr[2] = 4'hF;
    send_word(10'd7, 5'd3, 5'd0);
    wait_drain();

    // Wrapping read pointer, then an empty word
    rand_data();
    send_word(10'd9, 5'd19, 5'd14);
    wait_drain();
    send_word(10'd11, 5'd7, 5'd7);
    repeat (4) @(negedge clk);
    check("empty_rdy", 32'(in_rdy), 32'd1);
    check("empty_vld", 32'(out_vld), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back full words
    max_streak = 0;
    rand_data();
    send_word(10'd20, 5'd16, 5'd0);
    rand_data();
    send_word(10'd21, 5'd16, 5'd0);
    wait_drain();
    check("b2b_streak", 32'(max_streak), 32'd32);

    // Random words under random backpressure
    rnd_bp = 1'b1;
    for (int w = 0; w < 100; w++) begin
      rand_data();
      rp = PW'($urandom_range(0, 31)) | (5'($urandom_range(0, 1)) << PW);
      send_word((w % 10 == 3) ? KW'(LWE_K) : KW'($urandom_range(0, 1023)),
                rp + 5'($urandom_range(0, NB)), rp);
    end
    wait_drain();
    rnd_bp = 1'b0;
    @(posedge clk);
    #1;

    // Flush in the middle of a word
    rand_data();
    base = pops;
    send_word(10'd30, 5'd16, 5'd0);
    n = 0;
    while (pops < base + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("flush_wait", 32'(pops >= base + 3), 32'd1);
    @(posedge clk);
    #1;
    in_flush = 1'b1;
    in_vld = 1'b1;
    @(negedge clk);
    check("flush_in_rdy", 32'(in_rdy), 32'd0);
    @(posedge clk);
    #1;
    in_flush = 1'b0;
    in_vld = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_vld", 32'(out_vld), 32'd0);
    check("flush_rdy_after", 32'(in_rdy), 32'd1);
    check("flush_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    rand_data();
    send_word(10'd31, 5'd8, 5'd3);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
